// File: rtl/dvp_camera_tx_if.sv
// Pixel-stream handshake plus the DVP output bus of dvp_camera_tx.
//
// Signals:
//   pix_data  [23:0]  {R8,G8,B8} pixel from the frame source
//   pix_valid         pix_data is valid
//   pix_ready         camera model takes a pixel this cycle
//   vsync             frame sync
//   href              line valid
//   d         [7:0]   byte-serial RGB565
//
// Modports:
//   master  the camera model side (consumes pixels, drives the DVP bus)
//   slave   the source / capture side (supplies pixels, observes the DVP bus)
interface dvp_camera_tx_if;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        vsync;
    logic        href;
    logic [7:0]  d;

    modport master (
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        output vsync,
        output href,
        output d
    );

    modport slave (
        output pix_data,
        output pix_valid,
        input  pix_ready,
        input  vsync,
        input  href,
        input  d
    );
endinterface

// File: rtl/dvp_camera_tx.sv
// DVP (OV7670-style) camera transmitter: turns a 24-bit RGB pixel stream into
// vsync / href / byte-serial RGB565 frame timing, every output registered on pclk.
//
// Ports:
//   pclk         clock
//   rst          synchronous active-high reset
//   enable       run frames back-to-back while high; a started frame always completes
//   pattern_sel  select internal colour bars for the next frame (DVP_TEST_PATTERN_EN only)
//   frame_start  one-cycle pulse in the first vsync cycle
//   frame_done   one-cycle pulse in the last front-porch cycle
//   underflow    sticky: a pixel slot found pix_valid low (cleared by rst only)
//   bus          dvp_camera_tx_if.master: pix_data/pix_valid/pix_ready, vsync/href/d
//
// Optional feature: define DVP_TEST_PATTERN_EN to build the eight-bar colour generator.
module dvp_camera_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               enable,
    input  logic               pattern_sel,
    output logic               frame_start,
    output logic               frame_done,
    output logic               underflow,
    dvp_camera_tx_if.master    bus
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int BYTES     = 2 * H_ACTIVE;
    localparam int VS_LEN    = VSYNC_LINES * LINE_LEN;
    localparam int VB_LEN    = V_BACK * LINE_LEN;
    localparam int VF_LEN    = V_FRONT * LINE_LEN;
    localparam int BLANK_MAX = max2(max2(VS_LEN, VB_LEN), max2(VF_LEN, H_BLANK));
    localparam int BYTE_W    = $clog2(BYTES);
    localparam int LINE_W    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BLANK_W   = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

    localparam logic [BLANK_W-1:0] VS_LAST   = BLANK_W'(VS_LEN - 1);
    localparam logic [BLANK_W-1:0] VB_LAST   = BLANK_W'(VB_LEN - 1);
    localparam logic [BLANK_W-1:0] VF_LAST   = BLANK_W'(VF_LEN - 1);
    localparam logic [BLANK_W-1:0] HB_LAST   = BLANK_W'(H_BLANK - 1);
    localparam logic [BYTE_W-1:0]  BYTE_LAST = BYTE_W'(BYTES - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST = LINE_W'(V_ACTIVE - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

    state_t               state, nxt_state;
    logic [BYTE_W-1:0]    byte_cnt;
    logic [LINE_W-1:0]    line_cnt;
    logic [BLANK_W-1:0]   blank_cnt;

    logic                 vsync_r, href_r, ready_r, start_r, done_r, uflow_r;
    logic [7:0]           d_r, lo_byte;
    logic                 vsync_nxt, href_nxt, ready_nxt, start_nxt, done_nxt, uflow_nxt;
    logic [7:0]           d_nxt, lo_nxt;

    logic                 pattern_on;
    logic [15:0]          bar_rgb;

`ifdef DVP_TEST_PATTERN_EN
    localparam logic [BYTE_W-1:0] BAR_BYTES = BYTE_W'(H_ACTIVE / 4);

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Pattern choice is frozen for the whole frame at VSYNC entry.
    always_ff @(posedge pclk) begin
        if (rst)
            pattern_on <= 1'b0;
        else if (state != VSYNC && nxt_state == VSYNC)
            pattern_on <= pattern_sel;
    end

    always_comb bar_rgb = bar_color(3'(byte_cnt / BAR_BYTES));
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign pattern_on         = 1'b0;
    assign bar_rgb            = '0;
`endif

    // State register and counters; counters restart on every state change.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            line_cnt  <= '0;
            blank_cnt <= '0;
        end else begin
            state <= nxt_state;
            if (nxt_state != state) begin
                byte_cnt  <= '0;
                blank_cnt <= '0;
            end else begin
                if (state == ACTIVE)
                    byte_cnt <= byte_cnt + 1'b1;
                if (state inside {VSYNC, VBACK, HBLANK, VFRONT})
                    blank_cnt <= blank_cnt + 1'b1;
            end
            // Line index spans ACTIVE/HBLANK alternations, so it restarts per frame.
            if (state != VSYNC && nxt_state == VSYNC)
                line_cnt <= '0;
            else if (state == HBLANK && nxt_state != HBLANK)
                line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE:    if (enable) nxt_state = VSYNC;
            VSYNC:   if (blank_cnt == VS_LAST) nxt_state = VBACK;
            VBACK:   if (blank_cnt == VB_LAST) nxt_state = ACTIVE;
            ACTIVE:  if (byte_cnt == BYTE_LAST) nxt_state = HBLANK;
            HBLANK:  if (blank_cnt == HB_LAST)
                         nxt_state = (line_cnt == LINE_LAST) ? VFRONT : ACTIVE;
            VFRONT:  if (blank_cnt == VF_LAST) nxt_state = enable ? VSYNC : IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are registered one cycle behind the state. pix_ready is the
    // exception: it must lead its high byte, so it is derived from nxt_state.
    always_comb begin
        vsync_nxt = (state == VSYNC);
        href_nxt  = (state == ACTIVE);
        start_nxt = (state == VSYNC) && (blank_cnt == '0);
        done_nxt  = (state == VFRONT) && (blank_cnt == VF_LAST);
        ready_nxt = (nxt_state == ACTIVE) && (state != ACTIVE || byte_cnt[0]) && !pattern_on;
        uflow_nxt = uflow_r;
        lo_nxt    = lo_byte;
        d_nxt     = '0;
        if (state == ACTIVE) begin
            if (pattern_on) begin
                d_nxt = byte_cnt[0] ? bar_rgb[7:0] : bar_rgb[15:8];
            end else if (!byte_cnt[0]) begin
                // ready_r is high in exactly these slots: this edge takes the pixel.
                if (bus.pix_valid) begin
                    d_nxt  = {bus.pix_data[23:19], bus.pix_data[15:13]};
                    lo_nxt = {bus.pix_data[12:10], bus.pix_data[7:3]};
                end else begin
                    d_nxt     = '0;
                    lo_nxt    = '0;
                    uflow_nxt = 1'b1;
                end
            end else begin
                d_nxt = lo_byte;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            ready_r <= 1'b0;
            start_r <= 1'b0;
            done_r  <= 1'b0;
            uflow_r <= 1'b0;
            d_r     <= '0;
            lo_byte <= '0;
        end else begin
            vsync_r <= vsync_nxt;
            href_r  <= href_nxt;
            ready_r <= ready_nxt;
            start_r <= start_nxt;
            done_r  <= done_nxt;
            uflow_r <= uflow_nxt;
            d_r     <= d_nxt;
            lo_byte <= lo_nxt;
        end
    end

    assign bus.vsync     = vsync_r;
    assign bus.href      = href_r;
    assign bus.d         = d_r;
    assign bus.pix_ready = ready_r;
    assign frame_start   = start_r;
    assign frame_done    = done_r;
    assign underflow     = uflow_r;
endmodule

// File: tb/tb_dvp_camera_tx.sv
// Directed bench for dvp_camera_tx with H_ACTIVE=8, H_BLANK=2, V_ACTIVE=2,
// VSYNC_LINES=1, V_BACK=1, V_FRONT=1 (line period 18, frame period 90).
// Cycle c is the clock period following edge c; edge 0 is the first edge that
// samples enable high. Outputs are sampled on the falling edge.
module tb_dvp_camera_tx;
    logic pclk = 1'b0;
    logic rst, enable, pattern_sel;
    logic frame_start, frame_done, underflow;

    dvp_camera_tx_if bus();

    dvp_camera_tx #(
        .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .pclk(pclk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .frame_start(frame_start), .frame_done(frame_done), .underflow(underflow),
        .bus(bus)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    logic [255:0] t_vs, t_hr, t_fs, t_fd, t_rdy, t_uf;
    logic [7:0]   dtr [0:255];
    int           uf_cycle, stop_cycle;
    logic         valid_level;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] span(input int lo, input int hi);
        logic [255:0] r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // pix_ready expected one cycle before each high byte of a frame starting at base.
    function automatic logic [255:0] ready_mask(input int base);
        logic [255:0] r = '0;
        for (int p = 0; p < 8; p++) begin
            r[base + 36 + 2 * p] = 1'b1;
            r[base + 54 + 2 * p] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [127:0] line_bytes(input int start);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = dtr[start + i];
        return r;
    endfunction

    task automatic capture(input int n);
        t_vs = '0; t_hr = '0; t_fs = '0; t_fd = '0; t_rdy = '0; t_uf = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge pclk);
            t_vs[c]  = bus.vsync;
            t_hr[c]  = bus.href;
            t_fs[c]  = frame_start;
            t_fd[c]  = frame_done;
            t_rdy[c] = bus.pix_ready;
            t_uf[c]  = underflow;
            dtr[c]   = bus.d;
            bus.pix_valid = valid_level && (c != uf_cycle);
            if (c == stop_cycle) enable = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_vsync"}, 256'(bus.vsync), '0);
        check_eq({tag, "_href"},  256'(bus.href), '0);
        check_eq({tag, "_d"},     256'(bus.d), '0);
        check_eq({tag, "_ready"}, 256'(bus.pix_ready), '0);
        check_eq({tag, "_fstart"}, 256'(frame_start), '0);
        check_eq({tag, "_fdone"}, 256'(frame_done), '0);
        check_eq({tag, "_uflow"}, 256'(underflow), '0);
    endtask

    localparam logic [127:0] LINE_FULL = 128'hFC08FC08FC08FC08FC08FC08FC08FC08;
    localparam logic [127:0] LINE_UF   = 128'hFC08FC080000FC08FC08FC08FC08FC08;

    initial begin
        logic [255:0] exp_hr;
        logic [255:0] win;
        int           nz;

        rst = 1'b1; enable = 1'b0; pattern_sel = 1'b0;
        bus.pix_valid = 1'b1; bus.pix_data = 24'hFF8040;
        valid_level = 1'b1; uf_cycle = -1; stop_cycle = -1;
        repeat (3) @(negedge pclk);
        check_all_zero("reset");

        rst = 1'b0;
        repeat (4) @(negedge pclk);
        check_eq("idle_vsync", 256'(bus.vsync), '0);

        // Two frames: underflow on pixel 2 of frame 2 line 0, enable dropped in frame 2 line 1.
        uf_cycle = 130; stop_cycle = 150; enable = 1'b1;
        capture(200);
        exp_hr = span(37, 52) | span(55, 70) | span(127, 142) | span(145, 160);
        check_eq("vsync",   t_vs,  span(1, 18) | span(91, 108));
        check_eq("fstart",  t_fs,  span(1, 1) | span(91, 91));
        check_eq("href",    t_hr,  exp_hr);
        check_eq("fdone",   t_fd,  span(90, 90) | span(180, 180));
        check_eq("ready",   t_rdy, ready_mask(0) | ready_mask(90));
        check_eq("ready_cnt_f1", 256'($countones(t_rdy & span(0, 89))), 256'(16));
        check_eq("vs_href_overlap", t_vs & t_hr, '0);
        check_eq("f1_line0", 256'(line_bytes(37)),  256'(LINE_FULL));
        check_eq("f1_line1", 256'(line_bytes(55)),  256'(LINE_FULL));
        check_eq("f2_line0_uf", 256'(line_bytes(127)), 256'(LINE_UF));
        check_eq("f2_line1", 256'(line_bytes(145)), 256'(LINE_FULL));
        check_eq("underflow", t_uf, span(131, 199));
        nz = 0;
        for (int c = 0; c < 200; c++) if (!exp_hr[c] && dtr[c] != 8'h00) nz++;
        check_eq("d_blank", 256'(nz), '0);

        // Reset in the middle of an active line, then restart.
        enable = 1'b1;
        repeat (45) @(negedge pclk);
        check_eq("mid_href", 256'(bus.href), 256'(1));
        check_eq("mid_uflow_sticky", 256'(underflow), 256'(1));
        rst = 1'b1;
        @(negedge pclk);
        check_all_zero("midrst");
        rst = 1'b0; enable = 1'b1; uf_cycle = -1; stop_cycle = -1;
        capture(96);
        win = span(0, 95);
        check_eq("re_vsync",  t_vs,  span(1, 18) | span(91, 95));
        check_eq("re_fstart", t_fs,  span(1, 1) | span(91, 91));
        check_eq("re_href",   t_hr,  span(37, 52) | span(55, 70));
        check_eq("re_fdone",  t_fd,  span(90, 90));
        check_eq("re_ready",  t_rdy, ready_mask(0) & win);
        check_eq("re_line0",  256'(line_bytes(37)), 256'(LINE_FULL));
        check_eq("re_uflow",  t_uf,  '0);

`ifdef DVP_TEST_PATTERN_EN
        rst = 1'b1; enable = 1'b0;
        @(negedge pclk);
        rst = 1'b0; enable = 1'b1; pattern_sel = 1'b1;
        valid_level = 1'b0; bus.pix_valid = 1'b0;
        capture(60);
        check_eq("bars_line0", 256'(line_bytes(37)),
                 256'(128'hFFFFFFE007FF07E0F81FF800001F0000));
        check_eq("bars_href",  t_hr,  span(37, 52) | span(55, 59));
        check_eq("bars_ready", t_rdy, '0);
        check_eq("bars_uflow", t_uf,  '0);
        enable = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
